// File: rtl/ty_axis_pkg.sv
// ty_axis_pkg: shared limits and types for the AXI-stream fork.
//   C_MAX_DATA_WIDTH : widest per-channel vector supported
//   count_t          : skid buffer occupancy (0, 1 or 2)
//   entry_t          : one buffered beat {tlast, tdata}
package ty_axis_pkg;
    localparam int C_MAX_DATA_WIDTH = 512;
    typedef logic [1:0] count_t;
    typedef struct packed {
        logic                        tlast;
        logic [C_MAX_DATA_WIDTH-1:0] tdata;
    } entry_t;
endpackage

// File: rtl/ty_axis_fork_tx_if.sv
// ty_axis_fork_tx_if: kernel-side single handshake plus the forked master channels.
//   ivalid/idata/iready          : kernel output word, all channels together
//   m_tvalid/m_tdata/m_tlast     : per-channel AXI-stream master outputs
//   m_tready                     : per-channel sink ready
//   master : the fork's view; slave : the kernel and sinks' view
interface ty_axis_fork_tx_if #(
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_NUM_CHANNELS = 2
);
    logic                                         ivalid;
    logic                                         iready;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  idata;
    logic [C_NUM_CHANNELS-1:0]                    m_tvalid;
    logic [C_NUM_CHANNELS-1:0]                    m_tlast;
    logic [C_NUM_CHANNELS-1:0]                    m_tready;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata;
    modport master (input ivalid, idata, m_tready, output iready, m_tvalid, m_tdata, m_tlast);
    modport slave  (output ivalid, idata, m_tready, input iready, m_tvalid, m_tdata, m_tlast);
endinterface

// File: rtl/ty_axis_skid2.sv
// ty_axis_skid2: single-channel 2-entry buffer; head entry drives the outputs.
//   push/push_last/push_data : write one beat
//   ready                    : sink ready; a pop happens when valid & ready
//   head_last/head_data      : oldest buffered beat
//   valid                    : buffer non-empty
//   full                     : two beats buffered
import ty_axis_pkg::*;
module ty_axis_skid2 #(
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    push,
    input  logic                    push_last,
    input  logic [C_DATA_WIDTH-1:0] push_data,
    input  logic                    ready,
    output logic                    head_last,
    output logic [C_DATA_WIDTH-1:0] head_data,
    output logic                    valid,
    output logic                    full
);
    count_t                cnt;
    logic                  pop;
    logic [C_DATA_WIDTH:0] entry, e0, e1;
    assign entry = {push_last, push_data};
    assign valid = cnt != 2'd0;
    assign full = cnt == 2'd2;
    assign pop = valid & ready;
    assign head_last = e0[C_DATA_WIDTH];
    assign head_data = e0[C_DATA_WIDTH-1:0];
    // e0 is always the head; e1 only holds the second beat while full
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            cnt <= '0;
            e0 <= '0;
            e1 <= '0;
        end else begin
            cnt <= cnt + count_t'(push) - count_t'(pop);
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
                e0 <= entry;
            else if (pop)
                e0 <= e1;
            if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop)))
                e1 <= entry;
        end
endmodule

// File: rtl/ty_axis_fork_tx.sv
// ty_axis_fork_tx: forks one kernel handshake onto independent AXI-stream channels.
//   aclk/areset : clock, asynchronous active-high reset
//   io          : kernel input word and per-channel master outputs
//   pkt_len     : beats per packet, 0 disables tlast
//   beat_cnt    : beat index within the current packet
import ty_axis_pkg::*;
module ty_axis_fork_tx #(
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_CNT_WIDTH    = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [C_CNT_WIDTH-1:0] pkt_len,
    output logic [C_CNT_WIDTH-1:0] beat_cnt,
    ty_axis_fork_tx_if.master      io
);
    if (C_DATA_WIDTH > C_MAX_DATA_WIDTH || C_NUM_CHANNELS < 1 || C_NUM_CHANNELS > 8) begin : g_bad
        $error("ty_axis_fork_tx: unsupported parameters");
    end
    logic [C_NUM_CHANNELS-1:0] full;
    logic [C_CNT_WIDTH-1:0]    len_q, len;
    logic                      accept, flag;
    // ready comes only from buffer occupancy, never from the sinks
    assign io.iready = ~areset & ~|full;
    assign accept = io.ivalid & io.iready;
    // the first beat of a packet uses the live pkt_len it is about to latch
    assign len = (beat_cnt == '0) ? pkt_len : len_q;
    assign flag = (len != '0) && (beat_cnt == len - C_CNT_WIDTH'(1));
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            beat_cnt <= '0;
            len_q <= '0;
        end else if (accept) begin
            if (beat_cnt == '0)
                len_q <= pkt_len;
            beat_cnt <= flag ? '0 : beat_cnt + C_CNT_WIDTH'(1);
        end
    for (genvar k = 0; k < C_NUM_CHANNELS; k++) begin : g_ch
        ty_axis_skid2 #(.C_DATA_WIDTH(C_DATA_WIDTH)) u_skid (
            .aclk      (aclk),
            .areset    (areset),
            .push      (accept),
            .push_last (flag),
            .push_data (io.idata[k]),
            .ready     (io.m_tready[k]),
            .head_last (io.m_tlast[k]),
            .head_data (io.m_tdata[k]),
            .valid     (io.m_tvalid[k]),
            .full      (full[k])
        );
    end
endmodule

// File: tb/tb_ty_axis_fork_tx.sv
// tb_ty_axis_fork_tx: scoreboard bench for the AXI-stream fork.
module tb_ty_axis_fork_tx;
    localparam int W = 32;
    localparam int N = 2;
    localparam int CW = 32;
    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [CW-1:0] pkt_len = '0;
    logic [CW-1:0] beat_cnt;
    int            vectors = 0;
    int            miscompares = 0;
    logic [W:0]    q [N][$];
    logic [CW-1:0] mb = '0;
    logic [CW-1:0] mlen = '0;

    ty_axis_fork_tx_if #(.C_DATA_WIDTH(W), .C_NUM_CHANNELS(N)) bus ();

    ty_axis_fork_tx #(.C_DATA_WIDTH(W), .C_NUM_CHANNELS(N), .C_CNT_WIDTH(CW)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .pkt_len  (pkt_len),
        .beat_cnt (beat_cnt),
        .io       (bus)
    );

    always #5 aclk = ~aclk;

    // samples on the falling edge; inputs only change 1 time unit after the rising edge
    task automatic monitor();
        logic [N-1:0]  stl;
        logic [W:0]    held [N];
        logic [W:0]    e, got;
        logic [CW-1:0] len;
        logic          flag;
        stl = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                for (int k = 0; k < N; k++) q[k].delete();
                mb = '0;
                stl = '0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    got = {bus.m_tlast[k], bus.m_tdata[k]};
                    if (stl[k]) begin
                        vectors++;
                        if (!bus.m_tvalid[k] || got !== held[k]) begin
                            miscompares++;
                            $display("FAIL hold ch%0d: got valid=%b beat=%h, required valid=1 beat=%h", k, bus.m_tvalid[k], got, held[k]);
                        end
                    end
                    if (bus.m_tvalid[k] && bus.m_tready[k]) begin
                        vectors++;
                        if (q[k].size() == 0) begin
                            miscompares++;
                            $display("FAIL spurious ch%0d: got beat=%h, required none", k, got);
                        end else begin
                            e = q[k].pop_front();
                            if (got !== e) begin
                                miscompares++;
                                $display("FAIL order ch%0d: got beat=%h, required %h", k, got, e);
                            end
                        end
                    end
                    stl[k] = bus.m_tvalid[k] && !bus.m_tready[k];
                    held[k] = got;
                end
                if (bus.ivalid && bus.iready) begin
                    len = (mb == '0) ? pkt_len : mlen;
                    if (mb == '0) mlen = pkt_len;
                    flag = (len != '0) && (mb == len - CW'(1));
                    vectors++;
                    if (beat_cnt !== mb) begin
                        miscompares++;
                        $display("FAIL beat_cnt: got %0d, required %0d", beat_cnt, mb);
                    end
                    for (int k = 0; k < N; k++) q[k].push_back({flag, bus.idata[k]});
                    mb = flag ? '0 : mb + CW'(1);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        areset = 1'b1;
        bus.ivalid = 1'b0;
        @(negedge aclk);
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        vectors++;
        if (bus.m_tvalid !== '0) begin miscompares++; $display("FAIL rst_tvalid: got %b, required 00", bus.m_tvalid); end
        vectors++;
        if (bus.m_tlast !== '0) begin miscompares++; $display("FAIL rst_tlast: got %b, required 00", bus.m_tlast); end
        vectors++;
        if (bus.m_tdata !== '0) begin miscompares++; $display("FAIL rst_tdata: got %h, required 0", bus.m_tdata); end
        vectors++;
        if (beat_cnt !== '0) begin miscompares++; $display("FAIL rst_beat_cnt: got %0d, required 0", beat_cnt); end
        vectors++;
        if (bus.iready !== 1'b0) begin miscompares++; $display("FAIL rst_iready: got %b, required 0", bus.iready); end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        vectors++;
        if (bus.iready !== 1'b1) begin miscompares++; $display("FAIL post_rst_iready: got %b, required 1", bus.iready); end
    endtask

    task automatic test_stream();
        for (int c = 0; c < 12; c++) begin
            @(posedge aclk); #1;
            bus.m_tready = '1;
            bus.ivalid = (c < 8);
            bus.idata[0] = W'(c);
            bus.idata[1] = W'(100 + c);
            @(negedge aclk);
            if (c < 8) begin
                vectors++;
                if (bus.iready !== 1'b1) begin miscompares++; $display("FAIL stream_iready c=%0d: got %b, required 1", c, bus.iready); end
            end
            if (c == 0) begin
                vectors++;
                if (bus.m_tvalid !== 2'b00) begin miscompares++; $display("FAIL stream_latency: got %b, required 00", bus.m_tvalid); end
            end
            if (c >= 1 && c <= 8) begin
                vectors++;
                if (bus.m_tvalid !== 2'b11 || bus.m_tdata[0] !== W'(c - 1) || bus.m_tdata[1] !== W'(99 + c))
                begin
                    miscompares++;
                    $display("FAIL stream_beat c=%0d: got v=%b %0d/%0d, required v=11 %0d/%0d", c, bus.m_tvalid, bus.m_tdata[0], bus.m_tdata[1], c - 1, 99 + c);
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (q[k].size() != 0) begin miscompares++; $display("FAIL stream_drain ch%0d: got %0d left, required 0", k, q[k].size()); end
        end
    endtask

    task automatic test_stall();
        int i, p0, p1;
        i = 0; p0 = 0; p1 = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(posedge aclk); #1;
            bus.m_tready = {c >= 6, 1'b1};
            bus.ivalid = (i < 8);
            bus.idata[0] = W'(16 + i);
            bus.idata[1] = W'(200 + i);
            @(negedge aclk);
            if (c == 2) begin
                vectors++;
                if (bus.iready !== 1'b0) begin miscompares++; $display("FAIL stall_iready: got %b, required 0", bus.iready); end
            end
            if (c >= 2 && c < 6) begin
                vectors++;
                if (bus.m_tvalid[1] !== 1'b1 || bus.m_tdata[1] !== W'(200))
                begin
                    miscompares++;
                    $display("FAIL stall_head c=%0d: got v=%b %0d, required v=1 200", c, bus.m_tvalid[1], bus.m_tdata[1]);
                end
            end
            if (c == 5) begin
                vectors++;
                if (p0 != 2) begin miscompares++; $display("FAIL stall_ch0_beats: got %0d, required 2", p0); end
            end
            p0 += int'(bus.m_tvalid[0] & bus.m_tready[0]);
            p1 += int'(bus.m_tvalid[1] & bus.m_tready[1]);
            if (bus.ivalid && bus.iready) i++;
        end
        vectors++;
        if (i != 8) begin miscompares++; $display("FAIL stall_accepts: got %0d, required 8", i); end
        vectors++;
        if (p0 != 8 || p1 != 8) begin miscompares++; $display("FAIL stall_totals: got %0d/%0d, required 8/8", p0, p1); end
    endtask

    task automatic test_tlast();
        logic [6:0] seen;
        int         i, j;
        int         bc [7];
        bc = '{0, 1, 2, 0, 1, 2, 0};
        seen = '0; i = 0; j = 0;
        do_reset();
        pkt_len = CW'(3);
        for (int c = 0; c < 12; c++) begin
            @(posedge aclk); #1;
            bus.m_tready = '1;
            bus.ivalid = (i < 7);
            bus.idata[0] = W'(300 + i);
            bus.idata[1] = W'(400 + i);
            @(negedge aclk);
            if (bus.m_tvalid[0] && bus.m_tready[0]) begin
                if (j < 7) seen[j] = bus.m_tlast[0];
                j++;
            end
            if (bus.ivalid && bus.iready) begin
                vectors++;
                if (beat_cnt !== CW'(bc[i])) begin miscompares++; $display("FAIL tlast_beat_cnt %0d: got %0d, required %0d", i, beat_cnt, bc[i]); end
                i++;
            end
        end
        vectors++;
        if (j != 7 || seen !== 7'b0100100) begin miscompares++; $display("FAIL tlast_pattern: got %0d beats %b, required 7 beats 0100100", j, seen); end
    endtask

    task automatic test_len_change();
        logic [4:0] seen;
        int         i, j;
        int         bc [5];
        bc = '{0, 1, 2, 0, 1};
        seen = '0; i = 0; j = 0;
        do_reset();
        pkt_len = CW'(3);
        for (int c = 0; c < 10; c++) begin
            @(posedge aclk); #1;
            bus.m_tready = '1;
            if (i == 2) pkt_len = CW'(2);
            bus.ivalid = (i < 5);
            bus.idata[0] = W'(500 + i);
            bus.idata[1] = W'(600 + i);
            @(negedge aclk);
            if (bus.m_tvalid[1] && bus.m_tready[1]) begin
                if (j < 5) seen[j] = bus.m_tlast[1];
                j++;
            end
            if (bus.ivalid && bus.iready) begin
                vectors++;
                if (beat_cnt !== CW'(bc[i])) begin miscompares++; $display("FAIL lenchg_beat_cnt %0d: got %0d, required %0d", i, beat_cnt, bc[i]); end
                i++;
            end
        end
        vectors++;
        if (j != 5 || seen !== 5'b10100) begin miscompares++; $display("FAIL lenchg_pattern: got %0d beats %b, required 5 beats 10100", j, seen); end
    endtask

    task automatic test_random();
        int         i;
        logic [W-1:0] d0, d1;
        void'($urandom(32'd1234));
        i = 0;
        d0 = $urandom;
        d1 = $urandom;
        do_reset();
        pkt_len = '0;
        for (int c = 0; c < 20000 && i < 1000; c++) begin
            @(posedge aclk); #1;
            bus.m_tready = 2'($urandom_range(0, 3));
            bus.ivalid = ($urandom_range(0, 3) != 0);
            bus.idata[0] = d0;
            bus.idata[1] = d1;
            @(negedge aclk);
            vectors++;
            if ((bus.m_tlast & bus.m_tvalid) !== '0) begin miscompares++; $display("FAIL rand_tlast: got %b, required 00", bus.m_tlast & bus.m_tvalid); end
            if (bus.ivalid && bus.iready) begin
                i++;
                d0 = $urandom;
                d1 = $urandom;
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk); #1;
            bus.m_tready = '1;
            bus.ivalid = 1'b0;
            @(negedge aclk);
        end
        vectors++;
        if (i != 1000) begin miscompares++; $display("FAIL rand_accepts: got %0d, required 1000", i); end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (q[k].size() != 0) begin miscompares++; $display("FAIL rand_drain ch%0d: got %0d left, required 0", k, q[k].size()); end
        end
    endtask

    task automatic test_reset_mid();
        int i;
        i = 0;
        do_reset();
        pkt_len = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge aclk); #1;
            bus.m_tready = '0;
            bus.ivalid = (i < 2);
            bus.idata[0] = W'(700 + i);
            bus.idata[1] = W'(800 + i);
            @(negedge aclk);
            if (bus.ivalid && bus.iready) i++;
        end
        vectors++;
        if (i != 2 || bus.m_tvalid !== 2'b11) begin miscompares++; $display("FAIL midrst_fill: got %0d beats v=%b, required 2 beats v=11", i, bus.m_tvalid); end
        @(posedge aclk); #1;
        areset = 1'b1;
        bus.ivalid = 1'b0;
        #1;
        vectors++;
        if (bus.m_tvalid !== '0) begin miscompares++; $display("FAIL midrst_tvalid: got %b, required 00", bus.m_tvalid); end
        vectors++;
        if (bus.m_tdata !== '0 || bus.m_tlast !== '0) begin miscompares++; $display("FAIL midrst_outputs: got %h last=%b, required 0", bus.m_tdata, bus.m_tlast); end
        vectors++;
        if (beat_cnt !== '0 || bus.iready !== 1'b0) begin miscompares++; $display("FAIL midrst_state: got cnt=%0d iready=%b, required 0/0", beat_cnt, bus.iready); end
        @(negedge aclk);
        @(posedge aclk); #1;
        areset = 1'b0;
        bus.m_tready = '1;
        @(posedge aclk); #1;
        bus.ivalid = 1'b1;
        bus.idata[0] = W'(777);
        bus.idata[1] = W'(888);
        @(negedge aclk);
        vectors++;
        if (bus.iready !== 1'b1 || beat_cnt !== '0) begin miscompares++; $display("FAIL midrst_restart: got iready=%b cnt=%0d, required 1/0", bus.iready, beat_cnt); end
        @(posedge aclk); #1;
        bus.ivalid = 1'b0;
        @(negedge aclk);
        vectors++;
        if (bus.m_tvalid !== 2'b11 || bus.m_tdata[0] !== W'(777) || bus.m_tdata[1] !== W'(888))
        begin
            miscompares++;
            $display("FAIL midrst_first: got v=%b %0d/%0d, required v=11 777/888", bus.m_tvalid, bus.m_tdata[0], bus.m_tdata[1]);
        end
        repeat (3) @(negedge aclk);
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (q[k].size() != 0) begin miscompares++; $display("FAIL midrst_drain ch%0d: got %0d left, required 0", k, q[k].size()); end
        end
    endtask

    initial begin
        bus.ivalid = 1'b0;
        bus.idata = '0;
        bus.m_tready = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_stream();
        test_stall();
        test_tlast();
        test_len_change();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
